servo_slew_sched: RTL and testbench

Command scheduler for the multi-servo hexapod leg datapath. It takes bytes from the UART receiver through a one-cycle data-valid strobe and parses them as 3-byte command packets (sync, channel, position). It holds a target position per servo channel and, once per 20 ms servo frame, moves each channel's commanded position toward its target by a bounded step. The per-channel position bytes drive the servo PWM generators; the frame tick and status flags go to the game/VGA logic.

---
 rtl/servo_slew_sched.sv | 147 ++++++++++++++
 tb/tb_servo_slew_sched.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/servo_slew_sched.sv
// Servo command scheduler: parses FF/channel/position packets into per-channel targets and slews positions once per frame.
// Latency: target write 1 clk after the position byte; o_pos moves only on frame wrap; no backpressure (i_rx_dv is never stalled).
module servo_slew_sched #(
    parameter int         NUM_CH       = 6,
    parameter int         FRAME_CLKS   = 320000,
    parameter int         STEP         = 4,
    parameter int         TIMEOUT_CLKS = 16000,
    parameter logic [7:0] SYNC         = 8'hFF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [7:0]            i_rx_byte,
    input  logic                  i_rx_dv,
    output logic [8*NUM_CH-1:0]   o_pos,
    output logic                  o_frame_tick,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int FW = $clog2(FRAME_CLKS + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CLKS - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CLKS - 1);
    localparam logic [8:0]    STEP9      = 9'(STEP);

    typedef enum logic [1:0] {S_SYNC, S_CHAN, S_POS} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               ch_q, ch_d;
    logic [TW-1:0]            to_q, to_d;
    logic [FW-1:0]            frame_q, frame_d;
    logic [NUM_CH-1:0][7:0]   tgt_q, tgt_d;
    logic [NUM_CH-1:0][7:0]   cur_q, cur_d;
    logic                     tick_q, tick_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;
    logic                     wrap;

    // 9-bit arithmetic keeps the clamp exact near 0 and 255.
    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] c9;
        logic [8:0] t9;
        c9   = {1'b0, cur};
        t9   = {1'b0, tgt};
        slew = cur;
        if (c9 < t9) begin
            slew = (c9 + STEP9 >= t9) ? tgt : 8'(c9 + STEP9);
        end else if (c9 > t9) begin
            slew = (c9 < t9 + STEP9) ? tgt : 8'(c9 - STEP9);
        end
    endfunction

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        tgt_d   = tgt_q;
        to_d    = to_q;
        err_d   = 1'b0;
        case (state_q)
            S_SYNC: begin
                to_d = '0;
                if (i_rx_dv && i_rx_byte == SYNC) state_d = S_CHAN;
            end
            S_CHAN: begin
                if (i_rx_dv) begin
                    if (i_rx_byte == SYNC) begin
                        state_d = S_CHAN;
                    end else if (i_rx_byte < 8'(NUM_CH)) begin
                        ch_d    = i_rx_byte[2:0];
                        state_d = S_POS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_SYNC;
                    end
                end
            end
            S_POS: begin
                if (i_rx_dv) begin
                    if (i_rx_byte == SYNC) begin
                        err_d   = 1'b1;
                        state_d = S_CHAN;
                    end else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (3'(i) == ch_q) tgt_d[i] = i_rx_byte;
                        end
                        state_d = S_SYNC;
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase
        // A byte arriving always wins over the timeout on the same cycle.
        if (state_q != S_SYNC) begin
            if (i_rx_dv) begin
                to_d = '0;
            end else if (to_q == TO_LAST) begin
                to_d    = '0;
                err_d   = 1'b1;
                state_d = S_SYNC;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_comb begin
        wrap    = (frame_q == FRAME_LAST);
        frame_d = wrap ? '0 : frame_q + 1'b1;
        tick_d  = wrap;
        cur_d   = cur_q;
        busy_d  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wrap) cur_d[i] = slew(cur_q[i], tgt_q[i]);
            if (cur_q[i] != tgt_q[i]) busy_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_SYNC;
            ch_q    <= '0;
            to_q    <= '0;
            frame_q <= '0;
            tgt_q   <= {NUM_CH{8'd128}};
            cur_q   <= {NUM_CH{8'd128}};
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            to_q    <= to_d;
            frame_q <= frame_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign o_pos        = cur_q;
    assign o_frame_tick = tick_q;
    assign o_busy       = busy_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_servo_slew_sched.sv
// Directed bench for servo_slew_sched with a short frame and timeout.
module tb_servo_slew_sched;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [7:0]  i_rx_byte = 8'h00;
    logic        i_rx_dv = 1'b0;
    logic [47:0] o_pos;
    logic        o_frame_tick;
    logic        o_busy;
    logic        o_err;

    int n_vec = 0;
    int n_mis = 0;
    int err_cnt = 0;
    int tick_cnt = 0;

    servo_slew_sched #(
        .NUM_CH(6), .FRAME_CLKS(100), .STEP(4), .TIMEOUT_CLKS(50), .SYNC(8'hFF)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .i_rx_byte(i_rx_byte), .i_rx_dv(i_rx_dv),
        .o_pos(o_pos), .o_frame_tick(o_frame_tick), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RST_N && o_err) err_cnt++;
        if (RST_N && o_frame_tick) tick_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pos(input int ch);
        pos = o_pos[ch*8 +: 8];
    endfunction

    // Caller sits on a negedge; the byte is consumed at the next posedge.
    task automatic send_byte(input logic [7:0] b);
        i_rx_byte = b;
        i_rx_dv   = 1'b1;
        @(negedge CLK);
        i_rx_dv   = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!o_frame_tick && n < 250);
        if (!o_frame_tick) chk("tick_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int e0;
        int first;
        int t0;

        // 1: reset state and first tick
        #12;
        chk("rst_pos", o_pos, {6{8'd128}});
        chk("rst_busy", o_busy, 0);
        chk("rst_err", o_err, 0);
        chk("rst_tick", o_frame_tick, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!o_frame_tick && n < 300);
        chk("first_tick_cycle", n, 100);

        // 2: ch2 128 -> 140
        send_byte(8'hFF); send_byte(8'h02); send_byte(8'h8C);
        chk("busy_pre", o_busy, 0);
        @(negedge CLK);
        chk("busy_rise", o_busy, 1);
        wait_tick(); chk("ch2_t1", pos(2), 132);
        wait_tick(); chk("ch2_t2", pos(2), 136);
        wait_tick(); chk("ch2_t3", pos(2), 140);
        chk("busy_at_t3", o_busy, 1);
        @(negedge CLK);
        chk("busy_fall", o_busy, 0);
        wait_tick();
        chk("ch2_hold", o_pos, 48'h808080_8C8080);

        // 3: bad channel, then clamped step on ch1
        e0 = err_cnt;
        send_byte(8'hFF); send_byte(8'h07);
        chk("badch_err", o_err, 1);
        @(negedge CLK);
        chk("badch_err_1cyc", o_err, 0);
        chk("badch_err_cnt", err_cnt - e0, 1);
        send_byte(8'hFF); send_byte(8'h01); send_byte(8'h7E);
        wait_tick();
        chk("ch1_clamp", o_pos, 48'h808080_8C7E80);

        // 4: resync then long downward ramp on ch3
        e0 = err_cnt;
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h03); send_byte(8'h0A);
        chk("resync_no_err", err_cnt - e0, 0);
        repeat (29) wait_tick();
        chk("ch3_t29", pos(3), 12);
        chk("ch3_busy", o_busy, 1);
        wait_tick(); chk("ch3_t30", pos(3), 10);
        wait_tick(); chk("ch3_t31", pos(3), 10);

        // 5: timeout, ignored stray byte, sync in position slot
        e0 = err_cnt;
        send_byte(8'hFF); send_byte(8'h01);
        first = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (o_err && first == 0) first = k;
        end
        chk("timeout_cycle", first, 50);
        chk("timeout_cnt", err_cnt - e0, 1);
        e0 = err_cnt;
        send_byte(8'h05);
        @(negedge CLK);
        chk("stray_no_err", err_cnt - e0, 0);
        send_byte(8'hFF); send_byte(8'h04); send_byte(8'hFF);
        chk("pos_sync_err", o_err, 1);
        send_byte(8'h04); send_byte(8'h90);
        @(negedge CLK);
        chk("in_chan_busy", o_busy, 1);
        chk("pos_sync_cnt", err_cnt - e0, 1);
        chk("ch1_kept", pos(1), 126);
        repeat (4) wait_tick();
        chk("ch4_done", pos(4), 144);

        // 6: position byte on the wrap edge, then reset mid-ramp
        wait_tick();
        repeat (97) @(negedge CLK);
        send_byte(8'hFF); send_byte(8'h00); send_byte(8'hA0);
        chk("wrap_tick", o_frame_tick, 1);
        chk("wrap_old_tgt", pos(0), 128);
        wait_tick();
        chk("wrap_next", pos(0), 132);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("arst_pos", o_pos, {6{8'd128}});
        chk("arst_busy", o_busy, 0);
        @(negedge CLK);
        e0 = err_cnt;
        t0 = tick_cnt;
        RST_N = 1'b1;
        repeat (20) @(negedge CLK);
        chk("rel_no_err", err_cnt - e0, 0);
        chk("rel_no_tick", tick_cnt - t0, 0);
        chk("rel_pos", o_pos, {6{8'd128}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
